// File: rtl/sevenseg_capture.sv
// Seven-segment pattern capture: debounces seg_in, decodes stable patterns 0-4/dash/error,
// and holds the result in a one-entry ready/valid buffer with overrun and error counters.
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_val,
  output logic       out_dash,
  output logic       out_err,
  output logic       overrun,
  output logic [7:0] err_count
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SEG_W = 7;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERR_SAT    = '1;

  typedef struct packed {
    logic [2:0] val;
    logic       dash;
    logic       err;
  } result_t;

  logic [SEG_W-1:0] seg_q, seg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  result_t          res_q, res_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic    same_c;
  logic    accept_c;
  logic    blank_c;
  logic    load_c;
  logic    drop_c;
  result_t dec_c;

  // Pattern decode; only consulted on accept, when seg_in already equals seg_q.
  always_comb begin
    dec_c = '0;
    case (seg_q)
      7'b1111110: dec_c.val = 3'd0;
      7'b0110000: dec_c.val = 3'd1;
      7'b1101101: dec_c.val = 3'd2;
      7'b1111001: dec_c.val = 3'd3;
      7'b0110011: dec_c.val = 3'd4;
      7'b0000001: begin
        dec_c.val  = 3'd7;
        dec_c.dash = 1'b1;
      end
      default:    dec_c.err = 1'b1;
    endcase
  end

  // Stability counter, accept detection and output buffer next-state.
  always_comb begin
    seg_d     = seg_in;
    cnt_d     = '0;
    valid_d   = valid_q;
    res_d     = res_q;
    overrun_d = overrun_q;
    err_cnt_d = err_cnt_q;

    same_c   = (seg_in == seg_q);
    accept_c = same_c && (cnt_q == CNT_ACCEPT);
    blank_c  = (seg_q == SEG_W'(0));
    load_c   = accept_c && !blank_c && (!valid_q || out_ready);
    drop_c   = accept_c && !blank_c && valid_q && !out_ready;

    if (same_c) begin
      cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end

    if (load_c) begin
      valid_d = 1'b1;
      res_d   = dec_c;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (drop_c) begin
      overrun_d = 1'b1;
    end

    // Dropped error patterns still count.
    if (accept_c && !blank_c && dec_c.err && (err_cnt_q != ERR_SAT)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      res_q     <= '0;
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      seg_q     <= seg_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      res_q     <= res_d;
      overrun_q <= overrun_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_val   = res_q.val;
  assign out_dash  = res_q.dash;
  assign out_err   = res_q.err;
  assign overrun   = overrun_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, legal range 1..255: the number of consecutive matching samples required before a pattern is accepted.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port seg_in, input, 7 bits: segment pattern {a,b,c,d,e,f,g}, bit6=a, active-high, already synchronous to clk.
REQ-005 The block SHALL have port out_ready, input, 1 bit: consumer accepts the held result.
REQ-006 The block SHALL have port out_valid, output, 1 bit: result held and available.
REQ-007 The block SHALL have port out_val, output, 3 bits: decoded digit.
REQ-008 The block SHALL have port out_dash, output, 1 bit: the result is a dash pattern.
REQ-009 The block SHALL have port out_err, output, 1 bit: the result is an unrecognised pattern.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a result was dropped.
REQ-011 The block SHALL have port err_count, output, 8 bits: saturating count of accepted unrecognised patterns.

Function
REQ-012 The block SHALL register seg_in into seg_q on every clock edge.
REQ-013 The stability counter SHALL update on every edge:
- seg_in == seg_q: cnt <= min(cnt+1, STABLE_CYCLES).
- otherwise: cnt <= 0.
REQ-014 An accept event SHALL occur on an edge where seg_in == seg_q and cnt == STABLE_CYCLES-1.
REQ-015 Accept timing SHALL be as follows: a pattern first sampled at edge t is accepted at edge t+STABLE_CYCLES, and out_valid is visible after that edge.
REQ-016 A held pattern SHALL produce exactly one accept; a new accept requires a change followed by renewed stability, and a re-stabilised identical pattern (P->Q->P) is accepted again.
REQ-017 Decode on accept SHALL map patterns as follows:
- 1111110->0.
- 0110000->1.
- 1101101->2.
- 1111001->3.
- 0110011->4.
- These five decodes set dash=0 and err=0.
REQ-018 Pattern 0000001 SHALL decode as a dash: out_val=3'd7, out_dash=1, out_err=0.
REQ-019 Pattern 0000000 (blank) SHALL be accepted silently, with no result load and no err_count change.
REQ-020 Any other pattern SHALL decode as an error: out_val=3'd0, out_dash=0, out_err=1.
REQ-021 The one-entry output buffer SHALL load a non-blank accept when out_valid==0 or (out_valid && out_ready), setting out_valid=1 with the new fields on the same edge.
REQ-022 A non-blank accept arriving while out_valid && !out_ready SHALL be dropped and set overrun=1; the held fields remain unchanged.
REQ-023 When out_valid && out_ready with no loadable accept, the block SHALL clear out_valid; out_val, out_dash and out_err retain their last values.
REQ-024 While out_valid && !out_ready, out_val, out_dash and out_err SHALL remain stable.
REQ-025 err_count SHALL increment by 1 on every accepted error pattern, including dropped ones, and saturate at 255.
REQ-026 overrun SHALL stay 1 until reset.
REQ-027 The block SHALL never deassert out_valid without the handshake (out_valid && out_ready).

Reset
REQ-028 When rst=1 at an edge, the block SHALL clear seg_q=0, cnt=0, out_valid=0, out_val=0, out_dash=0, out_err=0, overrun=0 and err_count=0.
REQ-029 rst SHALL take priority over every other event on the same edge.
REQ-030 Reset mid-stabilisation SHALL discard progress, so a pattern held through and after reset needs a full STABLE_CYCLES+1 samples after rst falls.
REQ-031 Blank input held after reset SHALL produce no output, since seg_q resets to blank.

Verification
REQ-032 Basic accept: STABLE_CYCLES=4, out_ready=1, seg_in=1101101 from edge t -> out_valid=1 and out_val=2 after edge t+4, for exactly one cycle.
REQ-033 Glitch: seg_in=0110011 for 3 edges, then 0110000 for 1 edge, then 0110011 for 5 edges -> no accept on the first run; a single accept of val=4 four edges after the return.
REQ-034 Dash and error: seg_in=0000001 stable -> val=7, dash=1; then 1010101 stable -> err=1, val=0, err_count=1; 256 alternating error/blank accepts -> err_count=255.
REQ-035 Backpressure: out_ready=0, accept 0 (1111110) then accept 3 (1111001) -> out_val=0 held, overrun=1; raise out_ready for 1 cycle -> out_valid=0.
REQ-036 Same-edge handshake: out_valid=1 and out_ready=1 on the same edge as an accept of 1 -> out_valid stays 1, out_val=1, overrun=0.
REQ-037 Reset: rst pulsed at cnt=2 with a stable pattern -> all outputs 0; the accept occurs STABLE_CYCLES edges after the first post-reset sample.
